// File: rtl/muldiv_unit_rv32_pkg.sv
// Shared types and helpers for the RV32M iterative multiply/divide unit.
// The operation encoding matches the funct3 field of the RV32M instructions.
package muldiv_pkg;

   localparam int MULDIV_XLEN_DEF  = 32;
   localparam int MULDIV_OPW_DEF   = 3;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } muldiv_state_e;

   function automatic logic is_div(input muldiv_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_rem(input muldiv_op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_signed_op1(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_op2(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_unit_rv32_if.sv
// Request/response bundle of the multiply/divide unit, named from the unit's side.
// The unit uses the slave modport; the issuing pipeline stage uses master.
interface muldiv_unit_rv32_if
   import muldiv_pkg::*;
#(
   parameter int XLEN     = MULDIV_XLEN_DEF,
   parameter int OP_WIDTH = MULDIV_OPW_DEF
);
   logic                i_valid;
   logic                o_ready;
   logic [OP_WIDTH-1:0] i_op;
   logic [XLEN-1:0]     i_op1;
   logic [XLEN-1:0]     i_op2;
   logic                i_flush;
   logic                o_valid;
   logic                i_ready;
   logic [XLEN-1:0]     o_result;

   modport slave (
      input  i_valid, i_op, i_op1, i_op2, i_flush, i_ready,
      output o_ready, o_valid, o_result
   );

   modport master (
      output i_valid, i_op, i_op1, i_op2, i_flush, i_ready,
      input  o_ready, o_valid, o_result
   );
endinterface

// File: rtl/muldiv_unit_rv32.sv
// Iterative RV32M multiply/divide: one bit per cycle on a single shared adder,
// shift-add for products and restoring division for quotient/remainder.
module muldiv_unit_rv32
   import muldiv_pkg::*;
#(
   parameter int XLEN     = MULDIV_XLEN_DEF,
   parameter int OP_WIDTH = MULDIV_OPW_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   muldiv_unit_rv32_if.slave  bus
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e       r_state;
   muldiv_state_e       w_state_next;
   muldiv_op_e          r_op;
   logic [CW-1:0]       r_cnt;
   logic [XLEN-1:0]     r_acc;
   logic [XLEN-1:0]     r_lo;
   logic [XLEN-1:0]     r_opnd;
   logic                r_neg;
   logic                r_neg_rem;
   logic [XLEN-1:0]     r_result;

   logic                w_ready;
   logic                w_valid;
   logic                w_accept;
   muldiv_op_e          w_op;
   logic                w_sgn1;
   logic                w_sgn2;
   logic [XLEN-1:0]     w_mag1;
   logic [XLEN-1:0]     w_mag2;
   logic                w_div0;
   logic                w_ovf;
   logic                w_special;
   logic [XLEN-1:0]     w_special_result;

   logic                w_sub;
   logic [XLEN:0]       w_add_a;
   logic [XLEN:0]       w_add_b;
   logic [XLEN:0]       w_sum;
   logic [XLEN:0]       w_mul_step;
   logic                w_qbit;
   logic [2*XLEN-1:0]   w_prod;
   logic [2*XLEN-1:0]   w_prod_fix;
   logic [XLEN-1:0]     w_fix_result;

   // Request decode: operand magnitudes and the division corner cases
   assign w_op     = muldiv_op_e'(bus.i_op);
   assign w_accept = bus.i_valid && (r_state == IDLE) && !bus.i_flush;
   assign w_sgn1   = is_signed_op1(w_op) && bus.i_op1[XLEN-1];
   assign w_sgn2   = is_signed_op2(w_op) && bus.i_op2[XLEN-1];
   assign w_mag1   = w_sgn1 ? -bus.i_op1 : bus.i_op1;
   assign w_mag2   = w_sgn2 ? -bus.i_op2 : bus.i_op2;

   assign w_div0    = is_div(w_op) && (bus.i_op2 == '0);
   assign w_ovf     = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                      (bus.i_op1 == INT_MIN) && (bus.i_op2 == '1);
   assign w_special = w_div0 || w_ovf;

   always_comb begin
      w_special_result = '0;
      if (w_div0) begin
         w_special_result = is_rem(w_op) ? bus.i_op1 : '1;
      end else if (w_ovf) begin
         w_special_result = is_rem(w_op) ? '0 : bus.i_op1;
      end
   end

   // Shared adder: add multiplicand in multiply, trial-subtract divisor in divide
   always_comb begin
      w_sub   = is_div(r_op);
      w_add_a = w_sub ? {r_acc, r_lo[XLEN-1]} : {1'b0, r_acc};
      w_add_b = {1'b0, r_opnd};
      w_sum   = w_sub ? (w_add_a - w_add_b) : (w_add_a + w_add_b);
   end

   assign w_mul_step = r_lo[0] ? w_sum : {1'b0, r_acc};
   assign w_qbit     = ~w_sum[XLEN];

   assign w_prod     = {r_acc, r_lo};
   assign w_prod_fix = r_neg ? -w_prod : w_prod;

   always_comb begin
      w_fix_result = '0;
      if (is_div(r_op)) begin
         if (is_rem(r_op)) begin
            w_fix_result = r_neg_rem ? -r_acc : r_acc;
         end else begin
            w_fix_result = r_neg ? -r_lo : r_lo;
         end
      end else if (r_op == OP_MUL) begin
         w_fix_result = w_prod_fix[XLEN-1:0];
      end else begin
         w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      w_valid      = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (w_accept) begin
               w_state_next = w_special ? DONE : CALC;
            end
         end
         CALC: begin
            if (r_cnt == CNT_LAST) begin
               w_state_next = FIX;
            end
         end
         FIX: begin
            w_state_next = DONE;
         end
         DONE: begin
            w_valid = 1'b1;
            if (bus.i_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
      // Abort wins over accept and over handoff
      if (bus.i_flush) begin
         w_state_next = IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_op      <= OP_MUL;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_lo      <= '0;
         r_opnd    <= '0;
         r_neg     <= 1'b0;
         r_neg_rem <= 1'b0;
         r_result  <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op      <= w_op;
                  r_cnt     <= '0;
                  r_acc     <= '0;
                  r_neg     <= w_sgn1 ^ w_sgn2;
                  r_neg_rem <= w_sgn1;
                  if (is_div(w_op)) begin
                     r_opnd <= w_mag2;
                     r_lo   <= w_mag1;
                  end else begin
                     r_opnd <= w_mag1;
                     r_lo   <= w_mag2;
                  end
                  if (w_special) begin
                     r_result <= w_special_result;
                  end
               end
            end
            CALC: begin
               r_cnt <= r_cnt + CW'(1);
               if (is_div(r_op)) begin
                  r_acc <= w_qbit ? w_sum[XLEN-1:0] : w_add_a[XLEN-1:0];
                  r_lo  <= {r_lo[XLEN-2:0], w_qbit};
               end else begin
                  // {acc, lo} shifts right; the adder carry becomes the new acc MSB
                  r_acc <= w_mul_step[XLEN:1];
                  r_lo  <= {w_mul_step[0], r_lo[XLEN-1:1]};
               end
            end
            FIX: begin
               if (!bus.i_flush) begin
                  r_result <= w_fix_result;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_ready  = w_ready;
   assign bus.o_valid  = w_valid;
   assign bus.o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit_rv32.sv
// Directed bench for muldiv_unit_rv32: hand-computed RV32M vectors, latency,
// backpressure, flush and mid-operation reset.
module tb_muldiv_unit_rv32;
   import muldiv_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   muldiv_unit_rv32_if #(.XLEN(32), .OP_WIDTH(3)) bus ();

   muldiv_unit_rv32 #(.XLEN(32), .OP_WIDTH(3)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Returns at #1 after the accept edge, i.e. inside cycle 1; inputs are then scrambled.
   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_op    = op;
      bus.i_op1   = a;
      bus.i_op2   = b;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_op    = ~op;
      bus.i_op1   = ~a;
      bus.i_op2   = ~b;
   endtask

   task automatic wait_valid(input string tag, output int lat);
      int busy_bad;
      busy_bad = 0;
      lat      = 1;
      while (!bus.o_valid && lat < 100) begin
         if (bus.o_ready) busy_bad++;
         @(posedge clk);
         #1;
         lat++;
      end
      if (bus.o_ready) busy_bad++;
      check({tag, "/busy"}, busy_bad, 0);
   endtask

   task automatic handoff(input string tag);
      @(negedge clk);
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.i_ready = 1'b0;
      check({tag, "/idle"}, {30'd0, bus.o_ready, bus.o_valid}, 32'd2);
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      start_op(op, a, b);
      wait_valid(tag, lat);
      check({tag, "/lat"}, lat, exp_lat);
      check({tag, "/res"}, bus.o_result, exp);
      $display("%-10s op=%0d a=%08h b=%08h result=%08h cycles=%0d",
               tag, op, a, b, bus.o_result, lat);
      handoff(tag);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int lat;
      int seen;
      bus.i_valid = 1'b0;
      bus.i_op    = '0;
      bus.i_op1   = '0;
      bus.i_op2   = '0;
      bus.i_flush = 1'b0;
      bus.i_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst/ready",  {31'd0, bus.o_ready}, 32'd1);
      check("rst/valid",  {31'd0, bus.o_valid}, 32'd0);
      check("rst/result", bus.o_result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul",    OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
      run_op("mulh",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34);
      run_op("mulhu",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
      run_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
      run_op("div",    OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
      run_op("rem",    OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
      run_op("divu",   OP_DIVU,   32'd100,      32'd7,        32'd14,       34);
      run_op("remu",   OP_REMU,   32'd100,      32'd7,        32'd2,        34);
      run_op("divu0",  OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("remu0",  OP_REMU,   32'd5,        32'd0,        32'd5,        1);
      run_op("divovf", OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("removf", OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

      // Backpressure: result must hold and no new request may slip in
      start_op(OP_MUL, 32'd5, 32'd6);
      wait_valid("bp", lat);
      check("bp/res", bus.o_result, 32'd30);
      $display("%-10s op=%0d a=%08h b=%08h result=%08h cycles=%0d", "bp", OP_MUL, 32'd5, 32'd6, bus.o_result, lat);
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_op    = OP_DIVU;
      bus.i_op1   = 32'd9;
      bus.i_op2   = 32'd0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp/hold_valid", {31'd0, bus.o_valid}, 32'd1);
         check("bp/hold_res",   bus.o_result, 32'd30);
         check("bp/hold_ready", {31'd0, bus.o_ready}, 32'd0);
      end
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.i_ready = 1'b0;
      check("bp/idle", {30'd0, bus.o_ready, bus.o_valid}, 32'd2);
      repeat (2) @(posedge clk);
      #1;
      check("bp/no_accept", {30'd0, bus.o_ready, bus.o_valid}, 32'd2);

      // Flush in CALC cycle 10
      start_op(OP_DIVU, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      @(negedge clk);
      bus.i_flush = 1'b1;
      @(posedge clk);
      #1;
      bus.i_flush = 1'b0;
      check("flush/idle", {30'd0, bus.o_ready, bus.o_valid}, 32'd2);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.o_valid) seen++;
      end
      check("flush/no_valid", seen, 0);
      check("flush/res_hold", bus.o_result, 32'd30);
      $display("%-10s op=%0d a=%08h b=%08h aborted in cycle 10", "flush", OP_DIVU, 32'd100, 32'd7);

      // Asynchronous reset in CALC cycle 20, then a fresh operation
      start_op(OP_MUL, 32'h12345678, 32'd3);
      repeat (19) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst/result", bus.o_result, 32'd0);
      check("arst/valid",  {31'd0, bus.o_valid}, 32'd0);
      check("arst/ready",  {31'd0, bus.o_ready}, 32'd1);
      $display("%-10s op=%0d a=%08h b=%08h reset in cycle 20", "arst", OP_MUL, 32'h12345678, 32'd3);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("mul3x4", OP_MUL, 32'd3, 32'd4, 32'd12, 34);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
